// File: rtl/multiboot_seq_pkg.sv
// Shared word constants, state encoding and sizing for the MultiBoot sequencer.
// MULTIBOOT_FALLBACK_EN lengthens the SEND phase by the GENERAL_3/4 words.
package multiboot_pkg;

  localparam logic [15:0] SYNC1     = 16'hAA99;
  localparam logic [15:0] SYNC2     = 16'h5566;
  localparam logic [15:0] WR_CMD    = 16'h30A1;
  localparam logic [15:0] CMD_NULL  = 16'h0000;
  localparam logic [15:0] WR_GEN1   = 16'h3261;
  localparam logic [15:0] WR_GEN2   = 16'h3281;
  localparam logic [15:0] WR_GEN3   = 16'h32A1;
  localparam logic [15:0] WR_GEN4   = 16'h32C1;
  localparam logic [15:0] CMD_IPROG = 16'h000E;
  localparam logic [15:0] NOOP      = 16'h2000;
  localparam logic [15:0] IDLE_WORD = 16'hFFFF;

  localparam int IDX_W = 5;

`ifdef MULTIBOOT_FALLBACK_EN
  localparam int SEND_LEN = 14;
`else
  localparam int SEND_LEN = 10;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_TAIL = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/multiboot_seq_if.sv
// Request/status and ICAP output bundle of the MultiBoot sequencer.
// MULTIBOOT_FALLBACK_EN adds the golden-image address field.
interface multiboot_seq_if;
  logic        MBT_REBOOT;
  logic [23:0] MBT_ADDR;
`ifdef MULTIBOOT_FALLBACK_EN
  logic [23:0] MBT_FALLBACK_ADDR;
`endif
  logic        MBT_BUSY;
  logic        MBT_DONE;
  logic        ICAP_CE;
  logic        ICAP_WR;
  logic [15:0] ICAP_DIN;

  modport master (
    output MBT_REBOOT, MBT_ADDR,
`ifdef MULTIBOOT_FALLBACK_EN
    output MBT_FALLBACK_ADDR,
`endif
    input  MBT_BUSY, MBT_DONE, ICAP_CE, ICAP_WR, ICAP_DIN
  );

  modport slave (
    input  MBT_REBOOT, MBT_ADDR,
`ifdef MULTIBOOT_FALLBACK_EN
    input  MBT_FALLBACK_ADDR,
`endif
    output MBT_BUSY, MBT_DONE, ICAP_CE, ICAP_WR, ICAP_DIN
  );
endinterface

// File: rtl/multiboot_seq_icap_bitswap.sv
// Combinational per-byte bit reversal for SelectMAP ordering; pass-through when BITSWAP=0.
module icap_bitswap #(
  parameter bit BITSWAP = 1'b1
) (
  input  logic [15:0] din,
  output logic [15:0] dout
);
  if (BITSWAP) begin : g_swap
    for (genvar b = 0; b < 2; b++) begin : g_byte
      for (genvar i = 0; i < 8; i++) begin : g_bit
        assign dout[8*b + i] = din[8*b + 7 - i];
      end
    end
  end else begin : g_pass
    assign dout = din;
  end
endmodule

// File: rtl/multiboot_seq.sv
// ICAP warm-boot sequencer with runtime SPI address; one word per cycle, registered ICAP outputs.
// MULTIBOOT_FALLBACK_EN adds GENERAL_3/4 words; MULTIBOOT_ICAP_PRIM instantiates ICAP_SPARTAN6.
module multiboot_seq
  import multiboot_pkg::*;
#(
  parameter int         NOOP_CNT    = 4,
  parameter logic [7:0] READ_OPCODE = 8'h03,
  parameter bit         BITSWAP     = 1'b1
) (
  input  logic             CLK,
  input  logic             MBT_RESET_N,
  multiboot_seq_if.slave   mbt
);

  if (NOOP_CNT < 1 || NOOP_CNT > 15) begin : g_noop_range
    $error("multiboot_seq: NOOP_CNT must be in 1..15");
  end

  // Assertion is immediate; release is aligned to CLK.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge CLK or negedge MBT_RESET_N) begin
    if (!MBT_RESET_N) rst_sync <= 2'b00;
    else              rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [23:0]        addr_q, addr_n;
`ifdef MULTIBOOT_FALLBACK_EN
  logic [23:0]        fb_q, fb_n;
`endif
  logic [15:0]        word_n, word_sw;
  logic               ce_n, wr_n, busy_n, done_n;
  logic               ce_q, wr_q, busy_q, done_q;
  logic [15:0]        din_q;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    addr_n  = addr_q;
`ifdef MULTIBOOT_FALLBACK_EN
    fb_n    = fb_q;
`endif
    case (state)
      ST_IDLE: begin
        if (mbt.MBT_REBOOT) begin
          state_n = ST_SEND;
          idx_n   = '0;
          addr_n  = mbt.MBT_ADDR;
`ifdef MULTIBOOT_FALLBACK_EN
          fb_n    = mbt.MBT_FALLBACK_ADDR;
`endif
        end
      end
      ST_SEND: begin
        if (idx == IDX_W'(SEND_LEN - 1)) begin
          state_n = ST_TAIL;
          idx_n   = '0;
        end else begin
          idx_n = idx + IDX_W'(1);
        end
      end
      ST_TAIL: begin
        if (idx == IDX_W'(NOOP_CNT - 1)) state_n = ST_FIN;
        else                             idx_n   = idx + IDX_W'(1);
      end
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the first word lands one cycle after the request edge.
  always_comb begin
    word_n = IDLE_WORD;
    ce_n   = 1'b1;
    wr_n   = 1'b1;
    busy_n = 1'b0;
    done_n = 1'b0;
    case (state_n)
      ST_SEND: begin
        ce_n   = 1'b0;
        wr_n   = 1'b0;
        busy_n = 1'b1;
        case (idx_n)
          5'd0:    word_n = SYNC1;
          5'd1:    word_n = SYNC2;
          5'd2:    word_n = WR_CMD;
          5'd3:    word_n = CMD_NULL;
          5'd4:    word_n = WR_GEN1;
          5'd5:    word_n = addr_n[15:0];
          5'd6:    word_n = WR_GEN2;
          5'd7:    word_n = {READ_OPCODE, addr_n[23:16]};
`ifdef MULTIBOOT_FALLBACK_EN
          5'd8:    word_n = WR_GEN3;
          5'd9:    word_n = fb_n[15:0];
          5'd10:   word_n = WR_GEN4;
          5'd11:   word_n = {READ_OPCODE, fb_n[23:16]};
          5'd12:   word_n = WR_CMD;
          5'd13:   word_n = CMD_IPROG;
`else
          5'd8:    word_n = WR_CMD;
          5'd9:    word_n = CMD_IPROG;
`endif
          default: word_n = NOOP;
        endcase
      end
      ST_TAIL: begin
        ce_n   = 1'b0;
        wr_n   = 1'b0;
        busy_n = 1'b1;
        word_n = NOOP;
      end
      ST_FIN:  done_n = 1'b1;
      default: ;
    endcase
  end

  icap_bitswap #(.BITSWAP(BITSWAP)) u_bitswap (
    .din  (word_n),
    .dout (word_sw)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      addr_q <= '0;
`ifdef MULTIBOOT_FALLBACK_EN
      fb_q   <= '0;
`endif
      ce_q   <= 1'b1;
      wr_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      din_q  <= IDLE_WORD;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      addr_q <= addr_n;
`ifdef MULTIBOOT_FALLBACK_EN
      fb_q   <= fb_n;
`endif
      ce_q   <= ce_n;
      wr_q   <= wr_n;
      busy_q <= busy_n;
      done_q <= done_n;
      din_q  <= word_sw;
    end
  end

  assign mbt.ICAP_CE  = ce_q;
  assign mbt.ICAP_WR  = wr_q;
  assign mbt.ICAP_DIN = din_q;
  assign mbt.MBT_BUSY = busy_q;
  assign mbt.MBT_DONE = done_q;

`ifdef MULTIBOOT_ICAP_PRIM
  ICAP_SPARTAN6 u_icap (
    .BUSY  (),
    .O     (),
    .CE    (ce_q),
    .CLK   (CLK),
    .I     (din_q),
    .WRITE (wr_q)
  );
`endif

endmodule

// File: doc/multiboot_seq.md
Name: multiboot_seq

Overview:
- Parametrised successor to the fixed-address ICAP MultiBoot sequencer.
- On a reboot request it latches a runtime SPI boot address and streams the Spartan-6 ICAP warm-boot command sequence: sync, GENERAL_1/2, optional GENERAL_3/4 fallback, IPROG and a configurable NOOP tail.
- ICAP port signals are registered outputs. The top level instantiates ICAP_SPARTAN6 and drives it from these outputs; this enables core selection from the multi-core menu logic.

Parameters:
- NOOP_CNT, 4: trailing NOOP words after IPROG. Legal range 1..15; a value outside this range is an elaboration error.
- READ_OPCODE, 8'h03: SPI read opcode placed in GENERAL_2[15:8].
- BITSWAP, 1: when 1, bit-reverse each byte of the ICAP word, required for Spartan-6 SelectMAP ordering. When 0, the word passes straight through.

Ports:
- CLK  in  1  system clock, also the ICAP clock.
- MBT_RESET_N  in  1  asynchronous, active-low reset.
- MBT_REBOOT  in  1  reboot request, level-sampled at the CLK rising edge.
- MBT_ADDR  in  24  SPI byte address of the target bitstream.
- MBT_BUSY  out  1  high while a sequence is in progress.
- MBT_DONE  out  1  one-cycle pulse after the final word. In hardware the FPGA reconfigures, so this pulse is visible in simulation only.
- ICAP_CE  out  1  ICAP clock enable, active low.
- ICAP_WR  out  1  ICAP write, active low.
- ICAP_DIN  out  16  ICAP data after the optional byte bit-reversal.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, word index=0.
  - MBT_BUSY=0, MBT_DONE=0.
  - ICAP_CE=1, ICAP_WR=1, ICAP_DIN=16'hFFFF (16'hFFFF is bitswap-invariant).
- State machine: IDLE -> SEND -> TAIL -> FIN -> IDLE.
- IDLE:
  - An edge with MBT_REBOOT=1 latches MBT_ADDR into addr_q and moves to SEND.
  - From the next cycle: MBT_BUSY=1, ICAP_CE=0, ICAP_WR=0, ICAP_DIN=swap(word0).
- Latency: exactly one cycle from the sampling edge to word0 on ICAP_DIN.
- SEND: one word per cycle, in this order:
  - AA99, 5566, 30A1, 0000.
  - 3261, addr_q[15:0].
  - 3281, {READ_OPCODE, addr_q[23:16]}.
  - [fallback words, see Optional Feature].
  - 30A1, 000E.
- TAIL: NOOP_CNT words of 2000.
- FIN, one cycle:
  - ICAP_CE=1, ICAP_WR=1, ICAP_DIN=16'hFFFF.
  - MBT_DONE=1 for this cycle only; MBT_BUSY drops the same cycle.
  - Next state: IDLE.
- Total sequence length: 10 + NOOP_CNT words (+4 with the fallback feature). CE and WR stay continuously low across all words, with no gaps.
- Edge cases:
  - MBT_REBOOT while MBT_BUSY=1: ignored; addr_q is frozen for the whole sequence.
  - MBT_REBOOT held high through FIN: a new sequence starts from the first IDLE cycle's edge, giving exactly one idle output cycle between sequences.
  - MBT_RESET_N asserted mid-sequence: outputs go immediately to their idle values and the sequence is abandoned. No DONE pulse is produced, and there is no resumption.
  - MBT_ADDR changes during a sequence: no effect.
- Word index width: 5 bits. The index resets to 0 on entry to SEND and on entry to TAIL.

Optional Feature:
- Macro: MULTIBOOT_FALLBACK_EN.
- When defined:
  - Adds input port MBT_FALLBACK_ADDR[23:0], latched alongside MBT_ADDR.
  - Four words are inserted after the GENERAL_2 pair: 32A1, fb_q[15:0], 32C1, {READ_OPCODE, fb_q[23:16]} (GENERAL_3/4 golden-image address).
  - Sequence length becomes 14 + NOOP_CNT words.
- When undefined: the port is absent and the sequence is exactly as in Behaviour.

Decomposition:
- Shared package/include multiboot_pkg holds:
  - Word constants: SYNC1=16'hAA99, SYNC2=16'h5566, WR_CMD=16'h30A1, CMD_NULL=16'h0000, WR_GEN1=16'h3261, WR_GEN2=16'h3281, WR_GEN3=16'h32A1, WR_GEN4=16'h32C1, CMD_IPROG=16'h000E, NOOP=16'h2000, IDLE_WORD=16'hFFFF.
  - State encodings.
- Sub-module icap_bitswap: combinational per-byte bit reversal, BITSWAP parameter passed down. It sits before the output register.

Test Plan:
- Reset behaviour: hold MBT_RESET_N=0 -> ICAP_CE=1, ICAP_WR=1, ICAP_DIN=FFFF, MBT_BUSY=0.
- Basic reboot: MBT_ADDR=24'h0AC000, NOOP_CNT=4, BITSWAP=0, 1-cycle MBT_REBOOT ->
  - Words AA99, 5566, 30A1, 0000, 3261, C000, 3281, 030A, 30A1, 000E, 2000×4 on consecutive cycles.
  - CE and WR low for exactly 14 cycles, then MBT_DONE pulses for 1 cycle.
- Bitswap: BITSWAP=1 -> first word reads 16'h5599 (AA->55, 99->99). Decoding the swapped stream reproduces the basic-reboot sequence exactly.
- Busy protection: second MBT_REBOOT with MBT_ADDR=24'h123456 while busy -> ignored; GENERAL words still carry 0AC000.
- Reset mid-sequence: MBT_RESET_N low during word 6 -> outputs idle within the same cycle, no MBT_DONE. The next request produces a full, clean sequence.
- Fallback: MULTIBOOT_FALLBACK_EN, MBT_FALLBACK_ADDR=24'h000000 -> 32A1, 0000, 32C1, 0300 inserted after 030A; sequence length 18 words.
